// File: rtl/dla_vram_responder.sv
// Avalon-MM pixel-write responder: buffers writes in a FIFO and shares a
// single-port SRAM with display reads. Optional stats: DLA_VRAM_RESPONDER_STATS_EN.
module dla_vram_responder #(
   parameter int AVN_AW         = 19,
   parameter int AVN_DW         = 16,
   parameter int DEPTH          = 4,
   parameter int WR_CYCLES      = 2,
   parameter int RD_CYCLES      = 2,
   parameter int READ_BURST_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AVN_AW-1:0] avn_address,
   input  logic              avn_write,
   input  logic [AVN_DW-1:0] avn_writedata,
   output logic              avn_waitrequest,
   input  logic              vga_rd_req,
   input  logic [AVN_AW-1:0] vga_rd_addr,
   output logic [AVN_DW-1:0] vga_rd_data,
   output logic              vga_rd_valid,
   output logic [AVN_AW-1:0] sram_addr,
   output logic              sram_we,
   output logic              sram_oe,
   output logic [AVN_DW-1:0] sram_wdata,
   input  logic [AVN_DW-1:0] sram_rdata,
   output logic [31:0]       wr_count
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam int MAXC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
   localparam int YW   = $clog2(MAXC + 1);
   localparam int BW   = $clog2(READ_BURST_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE
   } state_t;

   state_t            state;
   logic [YW-1:0]     cyc;
   logic [BW-1:0]     burst_cnt;

   logic [AVN_AW-1:0] fifo_addr [DEPTH];
   logic [AVN_DW-1:0] fifo_data [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   logic              push;
   logic              pop;
   logic              nonempty;
   logic              rd_go;
   logic              wr_go;

   assign avn_waitrequest = (count == CW'(DEPTH));
   assign push     = avn_write & ~avn_waitrequest;
   assign nonempty = (count != '0);

   // Reads win unless a write has waited through a full read burst.
   assign rd_go = (state == S_IDLE) & vga_rd_req &
                  ~(nonempty & (burst_cnt == BW'(READ_BURST_MAX)));
   assign wr_go = (state == S_IDLE) & ~rd_go & nonempty;
   assign pop   = wr_go;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= avn_address;
         fifo_data[wr_ptr] <= avn_writedata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cyc          <= '0;
         burst_cnt    <= '0;
         sram_addr    <= '0;
         sram_wdata   <= '0;
         sram_we      <= 1'b0;
         sram_oe      <= 1'b0;
         vga_rd_data  <= '0;
         vga_rd_valid <= 1'b0;
      end else begin
         vga_rd_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               cyc <= '0;
               if (rd_go) begin
                  state     <= S_READ;
                  sram_addr <= vga_rd_addr;
                  sram_oe   <= 1'b1;
                  burst_cnt <= nonempty ? burst_cnt + BW'(1) : '0;
               end else if (wr_go) begin
                  state      <= S_WRITE;
                  sram_addr  <= fifo_addr[rd_ptr];
                  sram_wdata <= fifo_data[rd_ptr];
                  sram_we    <= 1'b1;
                  burst_cnt  <= '0;
               end
            end
            S_READ: begin
               if (cyc == YW'(RD_CYCLES - 1)) begin
                  state        <= S_IDLE;
                  sram_oe      <= 1'b0;
                  vga_rd_data  <= sram_rdata;
                  vga_rd_valid <= 1'b1;
               end else begin
                  cyc <= cyc + YW'(1);
               end
            end
            S_WRITE: begin
               if (cyc == YW'(WR_CYCLES - 1)) begin
                  state   <= S_IDLE;
                  sram_we <= 1'b0;
               end else begin
                  cyc <= cyc + YW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DLA_VRAM_RESPONDER_STATS_EN
   logic [31:0] wr_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wr_cnt_q <= '0;
      else if (push)
         wr_cnt_q <= wr_cnt_q + 32'd1;
   end

   assign wr_count = wr_cnt_q;
`else
   assign wr_count = '0;
`endif

endmodule
